// File: rtl/switch_debounce4.sv
// Four-channel switch conditioner: 2-flop sync + debounce per raw input.
// Ports: clk, rst_n (sync, active-low), p/q/r/s_raw in; p/q/r/s, changed, changed_mask out.
module switch_debounce4 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p_raw,
  input  logic       q_raw,
  input  logic       r_raw,
  input  logic       s_raw,
  output logic       p,
  output logic       q,
  output logic       r,
  output logic       s,
  output logic       changed,
  output logic [3:0] changed_mask
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [3:0]       mask_q;
  logic [3:0]       mask_d;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw = {s_raw, r_raw, q_raw, p_raw};

  // Count consecutive mismatches; the count restarts on any
  // agreeing cycle and on acceptance, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    mask_d   = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == LAST) begin
          stable_d[i] = sync2_q[i];
          mask_d[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      mask_q    <= mask_d;
      changed_q <= |mask_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign p            = stable_q[0];
  assign q            = stable_q[1];
  assign r            = stable_q[2];
  assign s            = stable_q[3];
  assign changed      = changed_q;
  assign changed_mask = mask_q;

endmodule
